// File: rtl/token_decoder_if.sv
// Bus bundle for token_decoder: start request, code/vocab read ports,
// output write port and completion flags.
interface token_decoder_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  cs;
    logic [ADDR_WIDTH-1:0] code_addr;
    logic [DATA_WIDTH-1:0] code_dout;
    logic [ADDR_WIDTH-1:0] vocab_addr;
    logic [DATA_WIDTH-1:0] vocab_dout;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_we;
    logic                  done;
    logic                  error;

    // decoder side
    modport master (
        input  cs, code_dout, vocab_dout,
        output code_addr, vocab_addr, out_addr, out_din, out_we, done, error
    );

    // host / memory side
    modport slave (
        output cs, code_dout, vocab_dout,
        input  code_addr, vocab_addr, out_addr, out_din, out_we, done, error
    );
endinterface

// File: rtl/token_decoder.sv
// Token decoder: reads codes, seeks the k-th zero-terminated word in the
// vocab memory and copies it to the output memory, then writes a 0 marker.
// Optional macro SEPARATOR_EN: writes SEP_CHAR before every word but the first.
// Read memories are synchronous: data is valid one cycle after the address.
module token_decoder #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEP_CHAR   = DATA_WIDTH'(8'h20)
) (
    input  logic             clk,
    input  logic             rst_n,
    token_decoder_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_CODE_RD, S_CODE_CHK, S_SEEK_RD, S_SEEK_CHK,
        S_COPY_RD, S_COPY_CHK, S_SEP, S_TERM, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE_A = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ONE_D = DATA_WIDTH'(1);

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_ca, w_ca, r_va, w_va, r_oa, w_oa;
    logic [DATA_WIDTH-1:0] r_cnt, w_cnt, r_code, w_code;
    logic                  r_ws, w_ws;          // va points at a word start
    logic                  r_we, w_we;
    logic [ADDR_WIDTH-1:0] r_out_addr, w_out_addr;
    logic [DATA_WIDTH-1:0] r_out_din, w_out_din;
    logic                  r_done, r_err;
`ifdef SEPARATOR_EN
    logic                  r_first, w_first;    // next word copied is the first
`endif

    // Addresses come straight from the pointers so the read issued in a
    // *_RD state (or held through SEP) returns data in the following *_CHK.
    assign bus.code_addr  = r_ca;
    assign bus.vocab_addr = r_va;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_din    = r_out_din;
    assign bus.out_we     = r_we;
    assign bus.done       = r_done;
    assign bus.error      = r_err;

    // Next-state and datapath decisions; writes are staged into r_out_*.
    always_comb begin
        w_state    = r_state;
        w_ca       = r_ca;
        w_va       = r_va;
        w_oa       = r_oa;
        w_cnt      = r_cnt;
        w_code     = r_code;
        w_ws       = r_ws;
        w_we       = 1'b0;
        w_out_addr = r_out_addr;
        w_out_din  = r_out_din;
`ifdef SEPARATOR_EN
        w_first    = r_first;
`endif
        case (r_state)
            S_IDLE: if (bus.cs) begin
                w_state = S_CODE_RD;
                w_ca    = '0;
                w_oa    = '0;
`ifdef SEPARATOR_EN
                w_first = 1'b1;
`endif
            end
            S_CODE_RD: w_state = S_CODE_CHK;
            S_CODE_CHK: begin
                w_code = bus.code_dout;
                if (bus.code_dout == '0) begin
                    w_state = S_TERM;
                end else begin
                    w_va    = '0;
                    w_cnt   = '0;
                    w_ws    = 1'b1;
                    w_state = S_SEEK_RD;
                end
            end
            S_SEEK_RD: w_state = S_SEEK_CHK;
            S_SEEK_CHK: begin
                if (r_ws && bus.vocab_dout == '0) begin
                    w_state = S_ERR;             // ran off the end of the vocab
                end else if (r_cnt == r_code - ONE_D) begin
`ifdef SEPARATOR_EN
                    w_first = 1'b0;
                    w_state = r_first ? S_COPY_CHK : S_SEP;
`else
                    w_state = S_COPY_CHK;
`endif
                end else if (r_va == '1) begin
                    w_state = S_ERR;             // seek would wrap the vocab
                end else begin
                    w_va    = r_va + ONE_A;
                    w_ws    = (bus.vocab_dout == '0);
                    if (bus.vocab_dout == '0) w_cnt = r_cnt + ONE_D;
                    w_state = S_SEEK_RD;
                end
            end
            S_SEP: begin
                if (r_oa == '1) begin
                    w_state = S_ERR;
                end else begin
                    w_we       = 1'b1;
                    w_out_addr = r_oa;
                    w_out_din  = SEP_CHAR;
                    w_oa       = r_oa + ONE_A;
                    w_state    = S_COPY_CHK;
                end
            end
            S_COPY_RD: w_state = S_COPY_CHK;
            S_COPY_CHK: begin
                if (bus.vocab_dout != '0) begin
                    if (r_oa == '1) begin
                        w_state = S_ERR;         // last slot reserved for the 0
                    end else begin
                        w_we       = 1'b1;
                        w_out_addr = r_oa;
                        w_out_din  = bus.vocab_dout;
                        w_oa       = r_oa + ONE_A;
                        w_va       = r_va + ONE_A;
                        w_state    = S_COPY_RD;
                    end
                end else if (r_ca == '1) begin
                    w_state = S_ERR;             // code stream not terminated
                end else begin
                    w_ca    = r_ca + ONE_A;
                    w_state = S_CODE_RD;
                end
            end
            S_TERM: begin
                w_we       = 1'b1;
                w_out_addr = r_oa;
                w_out_din  = '0;
                w_state    = S_DONE;
            end
            S_DONE:  w_state = S_DONE;
            S_ERR:   w_state = S_ERR;
            default: w_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state;
    end

    // Datapath registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ca       <= '0;
            r_va       <= '0;
            r_oa       <= '0;
            r_cnt      <= '0;
            r_code     <= '0;
            r_ws       <= 1'b0;
            r_we       <= 1'b0;
            r_out_addr <= '0;
            r_out_din  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
`ifdef SEPARATOR_EN
            r_first    <= 1'b0;
`endif
        end else begin
            r_ca       <= w_ca;
            r_va       <= w_va;
            r_oa       <= w_oa;
            r_cnt      <= w_cnt;
            r_code     <= w_code;
            r_ws       <= w_ws;
            r_we       <= w_we;
            r_out_addr <= w_out_addr;
            r_out_din  <= w_out_din;
            r_done     <= (w_state == S_DONE);
            r_err      <= (w_state == S_ERR);
`ifdef SEPARATOR_EN
            r_first    <= w_first;
`endif
        end
    end
endmodule

// File: tb/tb_token_decoder.sv
// Directed bench for token_decoder: table of vocab/code images with
// expected output bytes, plus reset, latency and mid-copy reset sequences.
module tb_token_decoder;
    typedef struct {
        string        name;
        logic [127:0] vocab;   // byte 0 in the top bits
        logic [127:0] codes;
        logic [127:0] exp;
        int           n;       // expected number of writes
        bit           done;
        bit           err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    token_decoder_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();
    token_decoder #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .SEP_CHAR(8'h20)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [7:0] code_mem  [16];
    logic [7:0] vocab_mem [16];
    always @(posedge clk) begin
        bus.code_dout  <= code_mem[bus.code_addr];
        bus.vocab_dout <= vocab_mem[bus.vocab_addr];
    end

    logic [3:0] wr_a [256];
    logic [7:0] wr_d [256];
    int n_wr = 0;
    always @(negedge clk) begin
        if (bus.out_we === 1'b1) begin
            if (n_wr < 256) begin
                wr_a[n_wr] <= bus.out_addr;
                wr_d[n_wr] <= bus.out_din;
            end
            n_wr <= n_wr + 1;
        end
    end

    int n_chk = 0;
    int n_pass = 0;
    vec_t vecs [8];

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        return b[(15-i)*8 +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            code_mem[i]  = byte_of(v.codes, i);
            vocab_mem[i] = byte_of(v.vocab, i);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.cs = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        @(negedge clk);
    endtask

    // Start with cs held high the whole run (must be ignored once busy),
    // wait for completion, linger to prove DONE/ERR absorb, then compare.
    task automatic start_and_check(input vec_t v);
        int base;
        int k;
        base = n_wr;
        bus.cs = 1'b1;
        for (k = 0; k < 400 && !(bus.done || bus.error); k++) @(negedge clk);
        if (k >= 400) begin
            n_chk++;
            $display("FAIL %s timeout: no done/error within 400 cycles", v.name);
        end
        repeat (4) @(negedge clk);
        bus.cs = 1'b0;
        check({v.name, " done"},   32'(bus.done),  32'(v.done));
        check({v.name, " error"},  32'(bus.error), 32'(v.err));
        check({v.name, " writes"}, 32'(n_wr - base), 32'(v.n));
        for (int i = 0; i < v.n && i < n_wr - base; i++)
            check($sformatf("%s byte%0d", v.name, i),
                  {20'h0, wr_a[base+i], wr_d[base+i]},
                  {20'h0, 4'(i), byte_of(v.exp, i)});
    endtask

    initial begin
        bus.cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            code_mem[i]  = 8'h00;
            vocab_mem[i] = 8'h00;
        end
        vecs[0] = '{"two_words", {"hi",8'h0,"yo",8'h0,8'h0,72'h0}, {8'd2,8'd1,8'd0,104'h0},
`ifdef SEPARATOR_EN
                    {"yo hi",8'h0,80'h0}, 6,
`else
                    {"yohi",8'h0,88'h0}, 5,
`endif
                    1'b1, 1'b0};
        vecs[1] = '{"empty_stream", {"hi",8'h0,"yo",8'h0,8'h0,72'h0}, 128'h0,
                    128'h0, 1, 1'b1, 1'b0};
        vecs[2] = '{"bad_code", {"hi",8'h0,"yo",8'h0,8'h0,72'h0}, {8'd3,8'd0,112'h0},
                    128'h0, 0, 1'b0, 1'b1};
        vecs[3] = '{"overflow", {"abcdefgh",8'h0,8'h0,48'h0}, {8'd1,8'd1,8'd0,104'h0},
`ifdef SEPARATOR_EN
                    {"abcdefgh abcdef",8'h0},
`else
                    {"abcdefghabcdefg",8'h0},
`endif
                    15, 1'b0, 1'b1};
        vecs[4] = '{"exact_fit", {"abcde",8'h0,8'h0,72'h0}, {8'd1,8'd1,8'd1,8'd0,96'h0},
`ifdef SEPARATOR_EN
                    {"abcde abcde abc",8'h0}, 15, 1'b0, 1'b1};
`else
                    {"abcdeabcdeabcde",8'h0}, 16, 1'b1, 1'b0};
`endif
        vecs[5] = '{"empty_vocab", 128'h0, {8'd1,8'd0,112'h0},
                    128'h0, 0, 1'b0, 1'b1};
        vecs[6] = '{"va_wrap", "abcdefghijklmnop", {8'd2,8'd0,112'h0},
                    128'h0, 0, 1'b0, 1'b1};
        vecs[7] = '{"third_word", {"a",8'h0,"bc",8'h0,"d",8'h0,8'h0,64'h0}, {8'd3,8'd2,8'd0,104'h0},
`ifdef SEPARATOR_EN
                    {"d bc",8'h0,88'h0}, 5,
`else
                    {"dbc",8'h0,96'h0}, 4,
`endif
                    1'b1, 1'b0};

        // Asynchronous reset clears every output without a clock edge.
        #3 rst_n = 1'b0;
        #1 check("reset outputs",
                 {15'h0, bus.code_addr, bus.vocab_addr, bus.out_addr, bus.out_din,
                  bus.out_we, bus.done, bus.error}, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            load(vecs[i]);
            do_reset();
            start_and_check(vecs[i]);
        end

        // Terminator latency: done and the single 0 write land together,
        // four edges after cs is first sampled.
        load(vecs[1]);
        do_reset();
        bus.cs = 1'b1;
        repeat (3) @(negedge clk);
        check("term pre done", {30'h0, bus.done, bus.out_we}, 32'h0);
        @(negedge clk);
        check("term write", {18'h0, bus.done, bus.error, bus.out_we, bus.out_addr, bus.out_din},
              {18'h0, 1'b1, 1'b0, 1'b1, 4'h0, 8'h00});
        @(negedge clk);
        bus.cs = 1'b0;
        check("term after", {29'h0, bus.done, bus.error, bus.out_we}, {29'h0, 3'b100});

        // Reset asserted during COPY_CHK, then a clean rerun.
        begin
            int k;
            int base;
            load(vecs[0]);
            do_reset();
            bus.cs = 1'b1;
            for (k = 0; k < 100 && bus.out_we !== 1'b1; k++) @(negedge clk);
            if (k >= 100) begin
                n_chk++;
                $display("FAIL midreset timeout: no write within 100 cycles");
            end
            bus.cs = 1'b0;
            @(negedge clk);              // write pulse was in COPY_RD; now COPY_CHK
            rst_n = 1'b0;
            #1 check("midreset outputs",
                     {15'h0, bus.code_addr, bus.vocab_addr, bus.out_addr, bus.out_din,
                      bus.out_we, bus.done, bus.error}, 32'h0);
            base = n_wr;
            repeat (3) @(negedge clk);
            check("midreset no writes", 32'(n_wr - base), 32'h0);
            rst_n = 1'b1;
            @(negedge clk);
            start_and_check(vecs[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
